// File: rtl/pad_bidir_ctrl.sv
// pad_bidir_ctrl: core-side controller for one bidirectional tristate pad.
// Sequences direction turnaround with hi-Z dead cycles and supports
// push-pull or open-drain drive. Synchronises and glitch-filters the pad
// readback and produces edge pulses.
// Optional feature macro: PAD_CONTENTION_CHK_EN enables a sticky
// drive/readback contention flag. When it is undefined, err_contention is 0.
module pad_bidir_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int TURN_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic tx_en,
   input  logic tx_data,
   input  logic od_mode,
   output logic pad_din,
   output logic pad_oe_n,
   input  logic pad_dout,
   output logic rx_data,
   output logic rx_rise,
   output logic rx_fall,
   output logic drive_active,
   input  logic err_clr,
   output logic err_contention
);

   // Turnaround counter holds up to TURN_CYCLES. Turn-on counts TURN_CYCLES
   // state cycles. Turn-off counts one extra cycle because the pad outputs
   // lag the state by one edge. The pad therefore sees TURN_CYCLES dead
   // cycles in both directions.
   localparam int TC_W = (TURN_CYCLES < 1) ? 1 : $clog2(TURN_CYCLES + 1);
   localparam logic [TC_W-1:0] TC_LOAD_OFF = TC_W'(TURN_CYCLES);
   localparam logic [TC_W-1:0] TC_LOAD_ON  = TC_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
   localparam int FC_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
   localparam logic [FC_W-1:0] FILT_MAX = FC_W'(FILT_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_TURN_ON  = 2'd1,
      S_DRIVE    = 2'd2,
      S_TURN_OFF = 2'd3
   } state_t;

   state_t          r_state;
   logic [TC_W-1:0] r_turn_cnt;
   logic            r_od;
   logic            r_drive_active;
   logic            r_pad_din;
   logic            r_pad_oe_n;
   logic            r_sync [SYNC_STAGES];
   logic [FC_W-1:0] r_filt_cnt;
   logic            r_rx_data;
   logic            r_rx_rise;
   logic            r_rx_fall;
   logic            w_synced;
   logic            w_blank;

   assign w_synced = r_sync[SYNC_STAGES-1];

   // Edge pulses are hidden while the core owns the line or is turning it
   // around. In open-drain DRIVE, external low-drivers must stay visible.
   assign w_blank = (r_state == S_TURN_ON) || (r_state == S_TURN_OFF) ||
                    ((r_state == S_DRIVE) && !r_od);

   // Readback synchroniser chain. It resets high to match the idle pull-up level.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            // first stage samples the asynchronous pad readback
            always_ff @(posedge clk) begin
               if (rst) r_sync[gi] <= 1'b1;
               else     r_sync[gi] <= pad_dout;
            end
         end else begin : g_rest
            // later stages shift the value down the chain
            always_ff @(posedge clk) begin
               if (rst) r_sync[gi] <= 1'b1;
               else     r_sync[gi] <= r_sync[gi-1];
            end
         end
      end
   endgenerate

   // Direction FSM. It registers drive_active in step with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_turn_cnt     <= '0;
         r_od           <= 1'b0;
         r_drive_active <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (tx_en) begin
                  r_od <= od_mode;
                  if (TURN_CYCLES == 0) begin
                     r_state        <= S_DRIVE;
                     r_drive_active <= 1'b1;
                  end else begin
                     r_state    <= S_TURN_ON;
                     r_turn_cnt <= TC_LOAD_ON;
                  end
               end
            end
            S_TURN_ON: begin
               if (!tx_en) begin
                  r_state <= S_IDLE;
               end else if (r_turn_cnt == '0) begin
                  r_state        <= S_DRIVE;
                  r_drive_active <= 1'b1;
               end else begin
                  r_turn_cnt <= r_turn_cnt - 1'b1;
               end
            end
            S_DRIVE: begin
               if (!tx_en) begin
                  r_drive_active <= 1'b0;
                  if (TURN_CYCLES == 0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state    <= S_TURN_OFF;
                     r_turn_cnt <= TC_LOAD_OFF;
                  end
               end
            end
            S_TURN_OFF: begin
               if (tx_en) begin
                  // Re-request restarts a full turn-on, so the dead time is never shortened.
                  r_state    <= S_TURN_ON;
                  r_turn_cnt <= TC_LOAD_ON;
               end else if (r_turn_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_turn_cnt <= r_turn_cnt - 1'b1;
               end
            end
            default: begin
               r_state        <= S_IDLE;
               r_drive_active <= 1'b0;
            end
         endcase
      end
   end

   // Pad drive registers. The line is only driven while the state is DRIVE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pad_oe_n <= 1'b1;
         r_pad_din  <= 1'b0;
      end else if (r_state == S_DRIVE) begin
         if (r_od) begin
            r_pad_din  <= 1'b0;
            r_pad_oe_n <= tx_data;
         end else begin
            r_pad_din  <= tx_data;
            r_pad_oe_n <= 1'b0;
         end
      end else begin
         r_pad_oe_n <= 1'b1;
         r_pad_din  <= 1'b0;
      end
   end

   // Glitch filter. A new level is accepted after FILT_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt_cnt <= '0;
         r_rx_data  <= 1'b1;
         r_rx_rise  <= 1'b0;
         r_rx_fall  <= 1'b0;
      end else begin
         r_rx_rise <= 1'b0;
         r_rx_fall <= 1'b0;
         if (w_synced != r_rx_data) begin
            if (r_filt_cnt == FILT_MAX) begin
               r_filt_cnt <= '0;
               r_rx_data  <= w_synced;
               r_rx_rise  <= w_synced && !w_blank;
               r_rx_fall  <= !w_synced && !w_blank;
            end else begin
               r_filt_cnt <= r_filt_cnt + 1'b1;
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   assign pad_din      = r_pad_din;
   assign pad_oe_n     = r_pad_oe_n;
   assign rx_data      = r_rx_data;
   assign rx_rise      = r_rx_rise;
   assign rx_fall      = r_rx_fall;
   assign drive_active = r_drive_active;

`ifdef PAD_CONTENTION_CHK_EN
   localparam int HOLD_W = $clog2(SYNC_STAGES + 2);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] r_hist_din;
   logic [SYNC_STAGES-1:0] r_hist_oe_n;
   logic [HOLD_W-1:0]      r_hold;
   logic [FC_W-1:0]        r_cfilt_cnt;
   logic                   r_err;
   logic                   w_mismatch;
   logic                   w_set;

   // A driven line is expected to read back the driven value. In open-drain
   // mode the driven value is always 0, so only a readback of 1 is flagged.
   assign w_mismatch = (r_state == S_DRIVE) && (r_hold == '0) &&
                       !r_hist_oe_n[SYNC_STAGES-1] &&
                       (w_synced != r_hist_din[SYNC_STAGES-1]);
   assign w_set      = w_mismatch && (r_cfilt_cnt == FILT_MAX);

   // Delay line of driven values. It is aligned with the synchroniser latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist_din  <= '0;
         r_hist_oe_n <= '1;
      end else begin
         r_hist_din  <= {r_hist_din[SYNC_STAGES-2:0], r_pad_din};
         r_hist_oe_n <= {r_hist_oe_n[SYNC_STAGES-2:0], r_pad_oe_n};
      end
   end

   // Checker hold-off after entering DRIVE, plus the consecutive-mismatch
   // filter and the sticky flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold      <= HOLD_LOAD;
         r_cfilt_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         if (r_state != S_DRIVE)  r_hold <= HOLD_LOAD;
         else if (r_hold != '0)   r_hold <= r_hold - 1'b1;
         if (!w_mismatch)                 r_cfilt_cnt <= '0;
         else if (r_cfilt_cnt != FILT_MAX) r_cfilt_cnt <= r_cfilt_cnt + 1'b1;
         if (w_set)        r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end

   assign err_contention = r_err;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign err_contention   = 1'b0;
`endif

endmodule

// File: tb/tb_pad_bidir_ctrl.sv
// tb_pad_bidir_ctrl: directed test of pad_bidir_ctrl with a resistive
// pull-up line model and an optional external driver.
module tb_pad_bidir_ctrl;

`ifdef PAD_CONTENTION_CHK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, tx_en, tx_data, od_mode, err_clr;
   logic ext_en, ext_val;
   logic pad_din, pad_oe_n, pad_line;
   logic rx_data, rx_rise, rx_fall, drive_active, err_contention;
   logic d2_din, d2_oe_n, d2_rx, d2_rise, d2_fall, d2_active, d2_err;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // Pull-up line: the external driver wins, then the DUT drive, else high.
   assign pad_line = ext_en ? ext_val : (pad_oe_n ? 1'b1 : pad_din);

   pad_bidir_ctrl #(.SYNC_STAGES(2), .FILT_LEN(4), .TURN_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data), .od_mode(od_mode),
      .pad_din(pad_din), .pad_oe_n(pad_oe_n), .pad_dout(pad_line),
      .rx_data(rx_data), .rx_rise(rx_rise), .rx_fall(rx_fall),
      .drive_active(drive_active), .err_clr(err_clr), .err_contention(err_contention)
   );

   pad_bidir_ctrl #(.SYNC_STAGES(2), .FILT_LEN(4), .TURN_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data), .od_mode(od_mode),
      .pad_din(d2_din), .pad_oe_n(d2_oe_n), .pad_dout(pad_line),
      .rx_data(d2_rx), .rx_rise(d2_rise), .rx_fall(d2_fall),
      .drive_active(d2_active), .err_clr(err_clr), .err_contention(d2_err)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; tx_en = 1'b0; tx_data = 1'b0; od_mode = 1'b0;
      err_clr = 1'b0; ext_en = 1'b0; ext_val = 1'b1;
      tick(3);
      rst = 1'b0;
      check("rst_oe_n", pad_oe_n, 1'b1);
      check("rst_din", pad_din, 1'b0);
      check("rst_rx", rx_data, 1'b1);
      check("rst_rise", rx_rise, 1'b0);
      check("rst_fall", rx_fall, 1'b0);
      check("rst_active", drive_active, 1'b0);
      check("rst_err", err_contention, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("idle_oe_n", pad_oe_n, 1'b1);
         check("idle_rx", rx_data, 1'b1);
         check("idle_pulse", rx_rise | rx_fall, 1'b0);
      end
      $display("step reset/idle done");

      // Push-pull turn-on, blanked edge, and turn-off
      tx_data = 1'b1; tx_en = 1'b1;
      tick(1);
      check("pp_k_oe_n", pad_oe_n, 1'b1);
      check("pp_k_active", drive_active, 1'b0);
      tick(1);
      check("pp_k1_oe_n", pad_oe_n, 1'b1);
      check("pp_k1_active", drive_active, 1'b1);
      tick(1);
      check("pp_k2_oe_n", pad_oe_n, 1'b0);
      check("pp_k2_din", pad_din, 1'b1);
      tx_data = 1'b0;
      tick(1);
      check("pp_din0", pad_din, 1'b0);
      check("pp_oe_n0", pad_oe_n, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check("pp_rx_lat", rx_data, (i == 6) ? 1'b0 : 1'b1);
         check("pp_fall_blank", rx_fall, 1'b0);
      end
      tx_data = 1'b1;
      tick(10);
      check("pp_rx_back", rx_data, 1'b1);
      tx_en = 1'b0;
      tick(1);
      check("pp_m_oe_n", pad_oe_n, 1'b0);
      check("pp_m_active", drive_active, 1'b0);
      tick(1);
      check("pp_m1_oe_n", pad_oe_n, 1'b1);
      tick(2);
      $display("step push-pull tx done");

      // Idle receive: clean fall, clean rise, short glitch
      ext_en = 1'b1; ext_val = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check("rx_fall_lvl", rx_data, (i < 6) ? 1'b1 : 1'b0);
         check("rx_fall_pulse", rx_fall, (i == 6) ? 1'b1 : 1'b0);
      end
      tick(1);
      check("rx_fall_once", rx_fall, 1'b0);
      ext_val = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check("rx_rise_lvl", rx_data, (i == 6) ? 1'b1 : 1'b0);
         check("rx_rise_pulse", rx_rise, (i == 6) ? 1'b1 : 1'b0);
      end
      ext_val = 1'b0;
      tick(3);
      ext_val = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("glitch_rx", rx_data, 1'b1);
         check("glitch_fall", rx_fall, 1'b0);
      end
      ext_en = 1'b0;
      $display("step idle rx done");

      // Open-drain drive and visible external low
      od_mode = 1'b1; tx_data = 1'b1; tx_en = 1'b1;
      tick(3);
      check("od_oe_n_1", pad_oe_n, 1'b1);
      check("od_din_a", pad_din, 1'b0);
      check("od_active", drive_active, 1'b1);
      tx_data = 1'b0;
      tick(1);
      check("od_oe_n_0", pad_oe_n, 1'b0);
      check("od_din_b", pad_din, 1'b0);
      tx_data = 1'b1;
      tick(1);
      check("od_oe_n_1b", pad_oe_n, 1'b1);
      tick(8);
      check("od_rx_hi", rx_data, 1'b1);
      ext_en = 1'b1; ext_val = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check("od_ext_fall", rx_fall, (i == 6) ? 1'b1 : 1'b0);
         check("od_ext_lvl", rx_data, (i < 6) ? 1'b1 : 1'b0);
      end
      ext_en = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check("od_ext_rise", rx_rise, (i == 6) ? 1'b1 : 1'b0);
      end
      tx_en = 1'b0; od_mode = 1'b0;
      tick(4);
      $display("step open-drain done");

      // One-cycle request is aborted in TURN_ON; then TURN_CYCLES=2 timing
      tx_en = 1'b1;
      tick(1);
      tx_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("pulse_oe_n_t1", pad_oe_n, 1'b1);
         check("pulse_oe_n_t2", d2_oe_n, 1'b1);
         check("pulse_act_t1", drive_active, 1'b0);
         check("pulse_act_t2", d2_active, 1'b0);
      end
      tx_en = 1'b1; tx_data = 1'b1;
      tick(3);
      check("t2_k2_oe_n", d2_oe_n, 1'b1);
      check("t2_k2_active", d2_active, 1'b1);
      tick(1);
      check("t2_k3_oe_n", d2_oe_n, 1'b0);
      tx_en = 1'b0;
      tick(6);
      $display("step turnaround abort done");

      // Contention: drive 1 while the line is forced low
      ext_en = 1'b1; ext_val = 1'b0; tx_data = 1'b1; tx_en = 1'b1;
      tick(8);
      check("cont_pre", err_contention, 1'b0);
      tick(1);
      check("cont_set", err_contention, CHK_EN);
      tx_en = 1'b0; ext_en = 1'b0;
      tick(10);
      check("cont_sticky", err_contention, CHK_EN);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("cont_clr", err_contention, 1'b0);
      tick(3);
      check("cont_clr_hold", err_contention, 1'b0);
      $display("step contention done");

      // Reset while driving low
      tx_data = 1'b0; tx_en = 1'b1;
      tick(10);
      check("mid_oe_n", pad_oe_n, 1'b0);
      check("mid_rx", rx_data, 1'b0);
      rst = 1'b1;
      tick(1);
      check("mrst_oe_n", pad_oe_n, 1'b1);
      check("mrst_din", pad_din, 1'b0);
      check("mrst_rx", rx_data, 1'b1);
      check("mrst_active", drive_active, 1'b0);
      rst = 1'b0; tx_en = 1'b0;
      tick(2);
      $display("step mid-op reset done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pad_bidir_ctrl.md
Name: pad_bidir_ctrl

Overview:
Core-side controller for one bidirectional tristate pad, opposite the pad primitive.
- Drives the pad's data-to-pad, active-low output enable and data-from-pad signals.
- Synchronises and glitch-filters the pad readback, detects edges and sequences direction turnaround with dead cycles.
- Supports push-pull and open-drain signalling; used for GPIO, 1-wire-style and I2C-style pins on the SoM.

Parameters:
SYNC_STAGES, 2, input synchroniser depth (>=2)
FILT_LEN, 4, consecutive identical synced samples required to accept a new level (>=1)
TURN_CYCLES, 1, hi-Z dead cycles on each direction change (>=0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_en  in  1  request to drive pad
tx_data  in  1  value to drive
od_mode  in  1  1 = open-drain (drive low only), 0 = push-pull; sampled only when leaving IDLE
pad_din  out  1  data to pad
pad_oe_n  out  1  pad output enable, active-low (0 = pad driven)
pad_dout  in  1  data from pad
rx_data  out  1  filtered pad level
rx_rise  out  1  one-cycle pulse on accepted 0->1
rx_fall  out  1  one-cycle pulse on accepted 1->0
drive_active  out  1  high while state is DRIVE
err_clr  in  1  clears err_contention (optional feature)
err_contention  out  1  sticky contention flag (optional feature)

Behaviour:
Reset values:
- pad_oe_n=1, pad_din=0, rx_data=1.
- rx_rise=rx_fall=0, drive_active=0, err_contention=0.
- Synchroniser flops=1, filter counter=0, state IDLE, od latch=0.

Outputs:
- All outputs are registered.
- tx_data affects pad_din/pad_oe_n one edge after it is sampled.

FSM states and transitions (tx_en sampled every edge):
- IDLE: pad_oe_n=1.
  - tx_en=1 -> TURN_ON; od_mode latched. If TURN_CYCLES=0 -> DRIVE directly.
- TURN_ON: hi-Z for TURN_CYCLES cycles, counted by a turnaround counter, then -> DRIVE.
  - tx_en=0 during TURN_ON -> IDLE immediately; the pad is never driven.
- DRIVE:
  - Push-pull: pad_oe_n=0, pad_din=tx_data.
  - Open-drain: pad_din=0, pad_oe_n=tx_data (drive low only when tx_data=0).
  - tx_en=0 -> TURN_OFF, with pad_oe_n=1 from the next edge. If TURN_CYCLES=0 -> IDLE.
- TURN_OFF: hi-Z for TURN_CYCLES cycles, then -> IDLE.
  - tx_en=1 during TURN_OFF -> TURN_ON with counter reloaded; the full dead time is always honoured.

Timing:
- tx_en rises, sampled at edge k: pad_oe_n=0 after edge k+1+TURN_CYCLES.
- tx_en falls, sampled at edge m: pad_oe_n=1 after edge m+1.

Receive path:
- pad_dout passes through SYNC_STAGES flops.
- Filter counter increments each cycle the synced value != rx_data and resets to 0 when equal.
- When the synced value has differed for FILT_LEN consecutive cycles, rx_data takes it on that edge; rx_rise/rx_fall pulse in the same cycle.
- Latency from a clean pad edge to rx_data change: SYNC_STAGES+FILT_LEN cycles.
- Pulses shorter than FILT_LEN cycles never change rx_data.
- Edge-pulse blanking: rx_rise/rx_fall suppressed in TURN_ON, TURN_OFF, and DRIVE in push-pull mode; rx_data still tracks.
- In open-drain DRIVE, pulses are not suppressed, so external low-drivers (stretching/arbitration) are visible.

Reset mid-operation: all state returns to reset values on the next edge; the pad is released within one cycle.

Optional Feature:
Macro PAD_CONTENTION_CHK_EN.
- With the macro: in DRIVE, err_contention sets when the synced readback differs from the value driven SYNC_STAGES+1 cycles earlier, for FILT_LEN consecutive cycles.
  - Push-pull: compare against pad_din.
  - Open-drain: flag only when driving low and readback=1.
  - Checking is disabled for SYNC_STAGES+1 cycles after entering DRIVE.
  - Sticky until err_clr=1 or rst; a set condition in the same cycle as err_clr wins.
- Without the macro: err_contention tied 0, err_clr ignored, no checker logic.

Test Plan:
- Reset, pad_dout=1 -> pad_oe_n=1, rx_data=1, no pulses for 20 cycles.
- TURN_CYCLES=1, tx_data=1, tx_en asserted at edge 10 -> pad_oe_n=0 after edge 12 with pad_din=1. Deassert at edge 20 -> pad_oe_n=1 after edge 21, IDLE after edge 22.
- Idle, pad_dout 1->0 held: rx_data=0 and rx_fall pulses exactly SYNC_STAGES+FILT_LEN (6) cycles later. A 3-cycle low glitch produces no change.
- od_mode=1, tx_data sequence 1,0,1 -> pad_oe_n sequence 1,0,1 with pad_din=0. An external low during tx_data=1 produces rx_fall.
- tx_en pulsed for one cycle with TURN_CYCLES=2 -> pad never driven (pad_oe_n stays 1), FSM returns to IDLE.
- With PAD_CONTENTION_CHK_EN: push-pull drive 1 while the bench forces pad 0 -> err_contention=1 and held; err_clr clears it. Without the macro it stays 0.
